// File: rtl/posit_accum_sched_es3_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | posit_accum_sched_es3_if : input stream, adder and result bus of the       |
// | posit sum-reduction scheduler.                                            |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
interface posit_accum_sched_es3_if #(
  parameter int NBITS = 32,
  parameter int CNT_W = 16
);
  logic [NBITS-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [NBITS-1:0] add_in1;
  logic [NBITS-1:0] add_in2;
  logic             add_start;
  logic [NBITS-1:0] add_result;
  logic             add_inf;
  logic             add_done;
  logic [NBITS-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_inf;
  logic [CNT_W-1:0] out_count;
  logic             err;

  modport slave (
    input  in_data, in_valid, in_last, add_result, add_inf, add_done, out_ready,
    output in_ready, add_in1, add_in2, add_start, out_data, out_valid, out_inf,
           out_count, err
  );

  modport master (
    output in_data, in_valid, in_last, add_result, add_inf, add_done, out_ready,
    input  in_ready, add_in1, add_in2, add_start, out_data, out_valid, out_inf,
           out_count, err
  );
endinterface
`default_nettype wire

// File: rtl/posit_accum_sched_es3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | posit_accum_sched_es3 : streaming sum-reduction scheduler that pairs input |
// | posits with returning adder results to hide the external adder latency.   |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
module posit_accum_sched_es3 #(
  parameter int NBITS   = 32,
  parameter int ADD_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  posit_accum_sched_es3_if.slave        bus
);
  localparam int                     c_drain_w    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [c_drain_w-1:0]   c_drain_last = c_drain_w'(ADD_LAT - 1);
  localparam logic [NBITS-1:0]       c_nar        = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [CNT_W-1:0]       c_cnt_max    = '1;

  typedef enum logic [1:0] {
    S_DRAIN = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_drain_w-1:0]   r_drain_cnt;
  logic [NBITS-1:0]       r_hold;
  logic                   r_hold_v;
  logic [2:0]             r_inflight;
  logic                   r_last_seen;
  logic [CNT_W-1:0]       r_count;
  logic                   r_inf;
  logic                   r_err;
  logic [NBITS-1:0]       r_add_in1;
  logic [NBITS-1:0]       r_add_in2;
  logic                   r_add_start;

  logic                   w_in_ready;
  logic                   w_i;
  logic                   w_a;
  logic                   w_dec;
  logic                   w_out_hs;
  logic                   w_issue;
  logic [NBITS-1:0]       w_op1;
  logic [NBITS-1:0]       w_op2;
  logic                   w_hold_load;
  logic                   w_hold_clr;
  logic [NBITS-1:0]       w_hold_din;

  assign w_in_ready = (r_state == S_ACCUM) && !r_last_seen;
  assign w_i        = bus.in_valid && w_in_ready;
  // add_done outside ACCUM never touches the datapath: DRAIN flushes, OUT only flags err
  assign w_a        = bus.add_done && (r_state == S_ACCUM);
  assign w_dec      = w_a && (r_inflight != 3'd0);
  assign w_out_hs   = (r_state == S_OUT) && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_data  = (r_state == S_OUT) ? r_hold : '0;
  assign bus.out_inf   = (r_state == S_OUT) && r_inf;
  assign bus.out_count = (r_state == S_OUT) ? r_count : '0;
  assign bus.err       = r_err;
  assign bus.add_in1   = r_add_in1;
  assign bus.add_in2   = r_add_in2;
  assign bus.add_start = r_add_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_DRAIN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_op1       = '0;
    w_op2       = '0;
    w_hold_load = 1'b0;
    w_hold_clr  = 1'b0;
    w_hold_din  = '0;
    case (r_state)
      S_DRAIN: begin
        if (r_drain_cnt == c_drain_last) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        // every operand either waits in the single hold slot or is paired immediately
        case ({w_a, w_i})
          2'b11: begin
            w_issue = 1'b1;
            w_op1   = bus.add_result;
            w_op2   = bus.in_data;
          end
          2'b10: begin
            if (r_hold_v) begin
              w_issue    = 1'b1;
              w_op1      = bus.add_result;
              w_op2      = r_hold;
              w_hold_clr = 1'b1;
            end else begin
              w_hold_load = 1'b1;
              w_hold_din  = bus.add_result;
            end
          end
          2'b01: begin
            if (r_hold_v) begin
              w_issue    = 1'b1;
              w_op1      = bus.in_data;
              w_op2      = r_hold;
              w_hold_clr = 1'b1;
            end else begin
              w_hold_load = 1'b1;
              w_hold_din  = bus.in_data;
            end
          end
          default: ;
        endcase
        if (r_last_seen && (r_inflight == 3'd0) && r_hold_v && !w_a) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) w_state_nxt = S_ACCUM;
      end
      default: w_state_nxt = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drain_cnt <= '0;
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
      r_inflight  <= 3'd0;
      r_last_seen <= 1'b0;
      r_count     <= '0;
      r_inf       <= 1'b0;
      r_err       <= 1'b0;
      r_add_in1   <= '0;
      r_add_in2   <= '0;
      r_add_start <= 1'b0;
    end else begin
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + c_drain_w'(1);

      r_add_start <= w_issue;
      if (w_issue) begin
        r_add_in1 <= w_op1;
        r_add_in2 <= w_op2;
      end

      if (w_out_hs) begin
        r_hold   <= '0;
        r_hold_v <= 1'b0;
      end else if (w_hold_load) begin
        r_hold   <= w_hold_din;
        r_hold_v <= 1'b1;
      end else if (w_hold_clr) begin
        r_hold_v <= 1'b0;
      end

      case ({w_issue, w_dec})
        2'b10:   if (r_inflight != 3'd7) r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: ;
      endcase

      if ((bus.add_done && (((r_state == S_ACCUM) && (r_inflight == 3'd0)) || (r_state == S_OUT)))
          || (w_issue && !w_dec && (r_inflight == 3'd7)))
        r_err <= 1'b1;

      if (w_out_hs) begin
        r_last_seen <= 1'b0;
        r_count     <= '0;
        r_inf       <= 1'b0;
      end else begin
        if (w_i && bus.in_last) r_last_seen <= 1'b1;
        if (w_i && (r_count != c_cnt_max)) r_count <= r_count + CNT_W'(1);
        if ((w_i && (bus.in_data == c_nar)) || (w_a && bus.add_inf)) r_inf <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_posit_accum_sched_es3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_posit_accum_sched_es3 : directed vectors for the posit sum scheduler,   |
// | with a latency-accurate adder stand-in.                                   |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_posit_accum_sched_es3;
  localparam int          NBITS   = 32;
  localparam int          ADD_LAT = 4;
  localparam int          CNT_W   = 16;
  // exponent width the golden sums below are encoded with
  localparam int          TB_ES   = 2;
  localparam logic [31:0] NAR     = 32'h8000_0000;
  localparam logic [31:0] ONE     = 32'h4000_0000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  posit_accum_sched_es3_if #(.NBITS(NBITS), .CNT_W(CNT_W)) ifc ();

  posit_accum_sched_es3 #(.NBITS(NBITS), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_starts = 0;
  logic force_done = 1'b0;

  logic [ADD_LAT-1:0]        pv = '0;
  logic [ADD_LAT-1:0][31:0]  pa = '0;
  logic [ADD_LAT-1:0][31:0]  pb = '0;

  function automatic real p2r(input logic [31:0] p);
    int  i, k, r, e, s;
    real f, w, v;
    logic b0;
    if (p == 32'd0) return 0.0;
    i = 30; k = 0; b0 = p[30];
    while (i >= 0 && p[i] == b0) begin k++; i--; end
    i--;
    r = b0 ? k - 1 : -k;
    e = 0;
    for (int j = 0; j < TB_ES; j++) begin
      e = (e << 1) | ((i >= 0 && p[i]) ? 1 : 0);
      i--;
    end
    f = 1.0; w = 0.5;
    while (i >= 0) begin
      if (p[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    s = r * (1 << TB_ES) + e;
    v = f;
    while (s > 0) begin v = v * 2.0; s--; end
    while (s < 0) begin v = v / 2.0; s++; end
    return v;
  endfunction

  function automatic logic [31:0] r2p(input real val);
    int s, r, e, pos;
    real v, f;
    logic [30:0] body;
    if (val <= 0.0) return 32'd0;
    v = val; s = 0;
    while (v >= 2.0) begin v = v / 2.0; s++; end
    while (v < 1.0)  begin v = v * 2.0; s--; end
    r = s >>> TB_ES;
    e = s - r * (1 << TB_ES);
    body = '0; pos = 30;
    if (r >= 0) begin
      for (int j = 0; j <= r; j++) begin
        if (pos >= 0) body[pos] = 1'b1;
        pos--;
      end
      pos--;
    end else begin
      pos = pos + r;
      if (pos >= 0) body[pos] = 1'b1;
      pos--;
    end
    for (int j = TB_ES - 1; j >= 0; j--) begin
      if (pos >= 0) body[pos] = ((e >> j) & 1) != 0;
      pos--;
    end
    f = v - 1.0;
    while (pos >= 0) begin
      f = f * 2.0;
      if (f >= 1.0) begin body[pos] = 1'b1; f = f - 1.0; end
      pos--;
    end
    return {1'b0, body};
  endfunction

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return NAR;
    return r2p(p2r(a) + p2r(b));
  endfunction

  // adder stand-in: fixed latency, unreset pipeline
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.add_start) n_starts <= n_starts + 1;
    pv <= {pv[ADD_LAT-2:0], ifc.add_start};
    pa <= {pa[ADD_LAT-2:0], ifc.add_in1};
    pb <= {pb[ADD_LAT-2:0], ifc.add_in2};
  end

  assign ifc.add_done   = pv[ADD_LAT-1] | force_done;
  assign ifc.add_result = model_add(pa[ADD_LAT-1], pb[ADD_LAT-1]);
  assign ifc.add_inf    = (pa[ADD_LAT-1] == NAR) || (pb[ADD_LAT-1] == NAR);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] val;
    int          nar_pos;
    logic [31:0] exp_data;
    logic        exp_inf;
    int          exp_adds;
    int          exp_lat;
  } vec_t;

  task automatic drive_set(input int n, input logic [31:0] val, input int nar_pos,
                           output int stalls, output int t_last);
    int waitc;
    stalls = 0;
    t_last = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_data  = (i == nar_pos) ? NAR : val;
      ifc.in_last  = (i == n - 1);
      waitc = 0;
      while (!ifc.in_ready && waitc < 50) begin
        stalls++;
        @(negedge clk);
        waitc++;
      end
      t_last = cyc;
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.in_data  = '0;
  endtask

  task automatic wait_out(output logic seen);
    int waitc = 0;
    while (!ifc.out_valid && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    seen = ifc.out_valid;
  endtask

  task automatic run_set(input vec_t v);
    int   s0, stalls, t_last;
    logic seen;
    s0 = n_starts;
    drive_set(v.n, v.val, v.nar_pos, stalls, t_last);
    wait_out(seen);
    check($sformatf("n%0d out_valid", v.n), {31'd0, seen}, 32'd1);
    check($sformatf("n%0d out_data", v.n), ifc.out_data, v.exp_data);
    check($sformatf("n%0d out_inf", v.n), {31'd0, ifc.out_inf}, {31'd0, v.exp_inf});
    check($sformatf("n%0d out_count", v.n), {16'd0, ifc.out_count}, v.n);
    check($sformatf("n%0d add_starts", v.n), n_starts - s0, v.exp_adds);
    check($sformatf("n%0d in_ready stalls", v.n), stalls, 0);
    if (v.exp_lat != 0) check($sformatf("n%0d latency", v.n), cyc - t_last, v.exp_lat);
    @(negedge clk);
    check($sformatf("n%0d out_valid after accept", v.n), {31'd0, ifc.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   t_rel, waitc, s0, stalls, t_last, bad_cycles, err_cycles;
    logic seen;
    logic [31:0] held;

    vecs[0] = '{n: 1, val: ONE, nar_pos: -1, exp_data: 32'h4000_0000, exp_inf: 1'b0, exp_adds: 0, exp_lat: 2};
    vecs[1] = '{n: 2, val: ONE, nar_pos: -1, exp_data: 32'h4800_0000, exp_inf: 1'b0, exp_adds: 1, exp_lat: 0};
    vecs[2] = '{n: 8, val: ONE, nar_pos: -1, exp_data: 32'h5800_0000, exp_inf: 1'b0, exp_adds: 7, exp_lat: 0};
    vecs[3] = '{n: 4, val: ONE, nar_pos:  2, exp_data: NAR,           exp_inf: 1'b1, exp_adds: 3, exp_lat: 0};
    vecs[4] = '{n: 2, val: ONE, nar_pos: -1, exp_data: 32'h4800_0000, exp_inf: 1'b0, exp_adds: 1, exp_lat: 0};
    vecs[5] = '{n: 3, val: ONE, nar_pos: -1, exp_data: 32'h4C00_0000, exp_inf: 1'b0, exp_adds: 2, exp_lat: 0};
    vecs[6] = '{n: 5, val: ONE, nar_pos: -1, exp_data: 32'h5200_0000, exp_inf: 1'b0, exp_adds: 4, exp_lat: 0};

    reset_n       = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("rst in_ready", {31'd0, ifc.in_ready}, 32'd0);
    check("rst add_start", {31'd0, ifc.add_start}, 32'd0);
    check("rst out_data", ifc.out_data, 32'd0);
    check("rst err", {31'd0, ifc.err}, 32'd0);

    // release, then poke add_done while the drain is running
    reset_n = 1'b1;
    t_rel = cyc;
    force_done = 1'b1;
    check("drain in_ready", {31'd0, ifc.in_ready}, 32'd0);
    @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check("drain add_done err", {31'd0, ifc.err}, 32'd0);
    waitc = 0;
    while (!ifc.in_ready && waitc < 50) begin @(negedge clk); waitc++; end
    check("drain length", cyc - t_rel, ADD_LAT);

    for (int k = 0; k < 7; k++) run_set(vecs[k]);

    // downstream back-pressure
    ifc.out_ready = 1'b0;
    drive_set(2, ONE, -1, stalls, t_last);
    wait_out(seen);
    check("bp out_valid", {31'd0, seen}, 32'd1);
    held = ifc.out_data;
    check("bp out_data", held, 32'h4800_0000);
    s0 = n_starts;
    bad_cycles = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = ONE;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!ifc.out_valid || ifc.out_data != held || ifc.in_ready) bad_cycles++;
    end
    ifc.in_valid = 1'b0;
    check("bp held cycles", bad_cycles, 0);
    check("bp add_starts", n_starts - s0, 0);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp released", {31'd0, ifc.out_valid}, 32'd0);
    check("bp count cleared", {16'd0, ifc.out_count}, 32'd0);

    // spurious add_done with nothing in flight is sticky
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check("spurious done err", {31'd0, ifc.err}, 32'd1);
    repeat (3) @(negedge clk);
    check("err sticky", {31'd0, ifc.err}, 32'd1);

    // reset in the middle of a set
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_data  = ONE;
      ifc.in_last  = 1'b0;
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst err", {31'd0, ifc.err}, 32'd0);
    check("midrst out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("midrst add_start", {31'd0, ifc.add_start}, 32'd0);
    check("midrst in_ready", {31'd0, ifc.in_ready}, 32'd0);
    check("midrst out_data", ifc.out_data, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bad_cycles = 0;
    err_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifc.out_valid) bad_cycles++;
      if (ifc.err) err_cycles++;
    end
    check("midrst stale out_valid", bad_cycles, 0);
    check("midrst stale err", err_cycles, 0);

    run_set(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
